// File: rtl/nn_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// nn_seq_ctrl_if
//
// Bundles the control and strobe signals between the inference sequencer and
// the datapath / memories. The parameters set the vector widths, and they
// must match the parameters of the nn_seq_ctrl instance that uses the bundle.
//
// Signals:
//   start, abort   -> sequencer : begin one inference / cancel the current one
//   busy, done     <- sequencer : run in progress / one-cycle completion pulse
//   bias_load      <- sequencer : one-hot per-neuron bias load strobe
//   pixel_addr     <- sequencer : pixel/weight memory read address
//   pixel_rd       <- sequencer : read enable while pixel_addr is live
//   valid_pixel    <- sequencer : pixel_rd aligned to the memory read latency
//   hid_addr       <- sequencer : hidden-neuron select for layer 2
//   hid_addr_d     <- sequencer : hid_addr delayed by one cycle
//   valid_hidden   <- sequencer : high while hid_addr is live
//   class_addr     <- sequencer : class-score select for argmax
//   valid_class    <- sequencer : high while class_addr is live
//
// Modports:
//   master : the sequencer side (drives the strobes and addresses)
//   slave  : the datapath / controller side (drives start and abort)
// ---------------------------------------------------------------------------
interface nn_seq_ctrl_if #(
    parameter int N_HID  = 10,
    parameter int PIX_AW = 12,
    parameter int HID_AW = 4,
    parameter int OUT_AW = 4
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [N_HID-1:0]  bias_load;
    logic [PIX_AW-1:0] pixel_addr;
    logic              pixel_rd;
    logic              valid_pixel;
    logic [HID_AW-1:0] hid_addr;
    logic [HID_AW-1:0] hid_addr_d;
    logic              valid_hidden;
    logic [OUT_AW-1:0] class_addr;
    logic              valid_class;

    modport master (
        input  start, abort,
        output busy, done, bias_load, pixel_addr, pixel_rd, valid_pixel,
               hid_addr, hid_addr_d, valid_hidden, class_addr, valid_class
    );

    modport slave (
        output start, abort,
        input  busy, done, bias_load, pixel_addr, pixel_rd, valid_pixel,
               hid_addr, hid_addr_d, valid_hidden, class_addr, valid_class
    );
endinterface

// File: rtl/nn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// nn_seq_ctrl
//
// Inference sequencer for the fully-connected MNIST datapath. A start pulse
// seen in IDLE runs the phases below in order:
//   BIAS   : walks a one-hot bias load strobe across the hidden neurons
//   PIXEL  : streams every pixel/weight address with a read enable
//   DRAIN1 : lets the memory-latency valid and the MAC pipeline empty
//   HIDDEN : sequences the hidden-layer outputs into the output layer
//   DRAIN2 : lets the layer-2 pipeline empty
//   ARGMAX : scans the class scores
//   DONE   : one-cycle done pulse, then back to IDLE
// An abort in any non-IDLE state returns to IDLE and clears every counter,
// strobe and delay line without a done pulse.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous, active-low reset
//   bus    : nn_seq_ctrl_if.master (start/abort in, all strobes out)
//
// Every output comes straight from a flop. The flops are loaded from the
// next-state and next-count values. This puts each output in the same cycle
// as the state it belongs to, without an extra cycle of lag.
// ---------------------------------------------------------------------------
module nn_seq_ctrl #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 10,
    parameter int N_OUT   = 10,
    parameter int PIX_AW  = 12,
    parameter int HID_AW  = 4,
    parameter int OUT_AW  = 4,
    parameter int MEM_LAT = 2,
    parameter int DRAIN   = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    nn_seq_ctrl_if.master bus
);

    // The shared phase counter must be able to hold the longest phase length.
    localparam int CNT_A   = (N_IN  > N_HID) ? N_IN  : N_HID;
    localparam int CNT_B   = (N_OUT > DRAIN) ? N_OUT : DRAIN;
    localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_PIXEL,
        S_DRAIN1,
        S_HIDDEN,
        S_DRAIN2,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_clr;

    logic [N_HID-1:0]   r_bias_load;
    logic [PIX_AW-1:0]  r_pixel_addr;
    logic               r_pixel_rd;
    logic [HID_AW-1:0]  r_hid_addr;
    logic [HID_AW-1:0]  r_hid_addr_d;
    logic               r_valid_hidden;
    logic [OUT_AW-1:0]  r_class_addr;
    logic               r_valid_class;
    logic               r_busy;
    logic               r_done;

    // Memory-latency delay line: tap 0 is the registered read enable, and
    // tap MEM_LAT is the aligned valid_pixel.
    logic [MEM_LAT-1:0] r_vp_sh;
    logic [MEM_LAT:0]   w_vp_tap;

    // Abort is ignored in IDLE, so clearing never disturbs an idle block.
    assign w_clr     = bus.abort && (r_state != S_IDLE);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state / next count. The counter restarts at 0 on every phase
    // change. Phase ends compare against length-1 at full counter width.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_inc;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (bus.start && !bus.abort) begin
                    w_state_next = S_BIAS;
                end
            end
            S_BIAS: begin
                if (r_cnt == CNT_W'(N_HID - 1)) begin
                    w_state_next = S_PIXEL;
                    w_cnt_next   = '0;
                end
            end
            S_PIXEL: begin
                if (r_cnt == CNT_W'(N_IN - 1)) begin
                    w_state_next = S_DRAIN1;
                    w_cnt_next   = '0;
                end
            end
            S_DRAIN1: begin
                if (r_cnt == CNT_W'(DRAIN - 1)) begin
                    w_state_next = S_HIDDEN;
                    w_cnt_next   = '0;
                end
            end
            S_HIDDEN: begin
                if (r_cnt == CNT_W'(N_HID - 1)) begin
                    w_state_next = S_DRAIN2;
                    w_cnt_next   = '0;
                end
            end
            S_DRAIN2: begin
                if (r_cnt == CNT_W'(DRAIN - 1)) begin
                    w_state_next = S_ARGMAX;
                    w_cnt_next   = '0;
                end
            end
            S_ARGMAX: begin
                if (r_cnt == CNT_W'(N_OUT - 1)) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (w_clr) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers, decoded from the next state. An abort forces the
    // next state to IDLE, so the strobes and addresses clear with it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias_load    <= '0;
            r_pixel_addr   <= '0;
            r_pixel_rd     <= 1'b0;
            r_hid_addr     <= '0;
            r_hid_addr_d   <= '0;
            r_valid_hidden <= 1'b0;
            r_class_addr   <= '0;
            r_valid_class  <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_bias_load    <= (w_state_next == S_BIAS) ? (N_HID'(1) << w_cnt_next) : '0;
            r_pixel_addr   <= (w_state_next == S_PIXEL) ? PIX_AW'(w_cnt_next) : '0;
            r_pixel_rd     <= (w_state_next == S_PIXEL);
            r_hid_addr     <= (w_state_next == S_HIDDEN) ? HID_AW'(w_cnt_next) : '0;
            r_hid_addr_d   <= w_clr ? '0 : r_hid_addr;
            r_valid_hidden <= (w_state_next == S_HIDDEN);
            r_class_addr   <= (w_state_next == S_ARGMAX) ? OUT_AW'(w_cnt_next) : '0;
            r_valid_class  <= (w_state_next == S_ARGMAX);
            r_busy         <= (w_state_next != S_IDLE);
            r_done         <= (w_state_next == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Read-latency alignment. The delay line keeps shifting after PIXEL
    // ends, so the valid for the final address lands inside DRAIN1.
    // ------------------------------------------------------------------
    assign w_vp_tap[0] = r_pixel_rd;

    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_vp_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vp_sh[gi] <= 1'b0;
                end else if (w_clr) begin
                    r_vp_sh[gi] <= 1'b0;
                end else begin
                    r_vp_sh[gi] <= w_vp_tap[gi];
                end
            end
            assign w_vp_tap[gi+1] = r_vp_sh[gi];
        end
    endgenerate

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.bias_load    = r_bias_load;
    assign bus.pixel_addr   = r_pixel_addr;
    assign bus.pixel_rd     = r_pixel_rd;
    assign bus.valid_pixel  = w_vp_tap[MEM_LAT];
    assign bus.hid_addr     = r_hid_addr;
    assign bus.hid_addr_d   = r_hid_addr_d;
    assign bus.valid_hidden = r_valid_hidden;
    assign bus.class_addr   = r_class_addr;
    assign bus.valid_class  = r_valid_class;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nn_seq_ctrl
//
// Scoreboard bench for nn_seq_ctrl.
//
// Main instance (default parameters):
//   - When a run starts, the reference model pushes every strobe it expects
//     into per-output queues. Each entry is stamped with its absolute cycle.
//     The model works from the phase lengths only.
//   - A negedge monitor pops and compares an entry whenever the DUT shows
//     that strobe. It also checks busy against the active-run intervals.
//   - An abort or reset drops the queued entries that lie after that point.
// Second instance (small parameters):
//   - Checked cycle by cycle for the done time, the valid_pixel lag and the
//     bias sequence.
// Cycle n means the clock period after edge n, where edge 0 samples start.
// ---------------------------------------------------------------------------
module tb_nn_seq_ctrl;

    localparam int N_IN    = 784;
    localparam int N_HID   = 10;
    localparam int N_OUT   = 10;
    localparam int MEM_LAT = 2;
    localparam int DRAIN   = 7;
    localparam int PIX_AW  = 12;
    localparam int HID_AW  = 4;
    localparam int OUT_AW  = 4;
    // Run length from the start edge up to and including the done cycle.
    localparam int D = 2*N_HID + N_IN + 2*DRAIN + N_OUT + 1;

    localparam int S_NIN = 16;
    localparam int S_NH  = 4;
    localparam int S_NO  = 3;
    localparam int S_ML  = 3;
    localparam int S_DR  = 3;
    localparam int S_D   = 2*S_NH + S_NIN + 2*S_DR + S_NO + 1;

    typedef struct {
        int cyc;
        int val;
        int val2;
    } ev_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic rst2_n = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    bit   sweep_done = 1'b0;

    ev_t q_bias[$];
    ev_t q_pix[$];
    ev_t q_vp[$];
    ev_t q_hid[$];
    ev_t q_cls[$];
    ev_t q_done[$];
    int  busy_lo[$];
    int  busy_hi[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nn_seq_ctrl_if #(.N_HID(N_HID), .PIX_AW(PIX_AW), .HID_AW(HID_AW), .OUT_AW(OUT_AW)) bus ();
    nn_seq_ctrl_if #(.N_HID(S_NH), .PIX_AW(4), .HID_AW(2), .OUT_AW(2)) bus2 ();

    nn_seq_ctrl #(
        .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .PIX_AW(PIX_AW),
        .HID_AW(HID_AW), .OUT_AW(OUT_AW), .MEM_LAT(MEM_LAT), .DRAIN(DRAIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    nn_seq_ctrl #(
        .N_IN(S_NIN), .N_HID(S_NH), .N_OUT(S_NO), .PIX_AW(4),
        .HID_AW(2), .OUT_AW(2), .MEM_LAT(S_ML), .DRAIN(S_DR)
    ) dut_small (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic ev_t mk(input int c, input int v, input int v2);
        ev_t e;
        e.cyc  = c;
        e.val  = v;
        e.val2 = v2;
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: lay out every expected strobe of one run from its base.
    task automatic push_run(input int b);
        int t;
        t = b + 1;
        for (int k = 0; k < N_HID; k++) q_bias.push_back(mk(t + k, 1 << k, 0));
        t += N_HID;
        for (int a = 0; a < N_IN; a++) begin
            q_pix.push_back(mk(t + a, a, 0));
            q_vp.push_back(mk(t + a + MEM_LAT, 1, 0));
        end
        t += N_IN + DRAIN;
        for (int h = 0; h < N_HID; h++) q_hid.push_back(mk(t + h, h, (h == 0) ? 0 : h - 1));
        t += N_HID + DRAIN;
        for (int c = 0; c < N_OUT; c++) q_cls.push_back(mk(t + c, c, 0));
        t += N_OUT;
        q_done.push_back(mk(t, 1, 0));
        busy_lo.push_back(b + 1);
        busy_hi.push_back(t);
    endtask

    // Cancel everything expected after cycle c (abort or reset seen in cycle c).
    task automatic purge(input int c);
        while (q_bias.size() > 0 && q_bias[$].cyc > c) void'(q_bias.pop_back());
        while (q_pix.size()  > 0 && q_pix[$].cyc  > c) void'(q_pix.pop_back());
        while (q_vp.size()   > 0 && q_vp[$].cyc   > c) void'(q_vp.pop_back());
        while (q_hid.size()  > 0 && q_hid[$].cyc  > c) void'(q_hid.pop_back());
        while (q_cls.size()  > 0 && q_cls[$].cyc  > c) void'(q_cls.pop_back());
        while (q_done.size() > 0 && q_done[$].cyc > c) void'(q_done.pop_back());
        for (int i = 0; i < busy_hi.size(); i++) begin
            if (busy_hi[i] > c) busy_hi[i] = c;
        end
    endtask

    function automatic ev_t pop_ev(input int k);
        ev_t e;
        e = mk(-1, 0, 0);
        case (k)
            0: if (q_bias.size() > 0) e = q_bias.pop_front();
            1: if (q_pix.size()  > 0) e = q_pix.pop_front();
            2: if (q_vp.size()   > 0) e = q_vp.pop_front();
            3: if (q_hid.size()  > 0) e = q_hid.pop_front();
            4: if (q_cls.size()  > 0) e = q_cls.pop_front();
            default: if (q_done.size() > 0) e = q_done.pop_front();
        endcase
        return e;
    endfunction

    task automatic check_ev(input int k, input string nm, input int val, input int val2);
        ev_t e;
        e = pop_ev(k);
        n_checks++;
        if (e.cyc < 0) begin
            n_errors++;
            $display("FAIL %s: unexpected strobe at cycle %0d value %0d, required none", nm, cyc, val);
        end else if (e.cyc != cyc || e.val != val || e.val2 != val2) begin
            n_errors++;
            $display("FAIL %s: got cycle %0d value %0d/%0d, required cycle %0d value %0d/%0d",
                     nm, cyc, val, val2, e.cyc, e.val, e.val2);
        end
    endtask

    function automatic int busy_model(input int c);
        int r;
        r = 0;
        for (int i = 0; i < busy_lo.size(); i++) begin
            if (c >= busy_lo[i] && c <= busy_hi[i]) r = 1;
        end
        return r;
    endfunction

    task automatic check_zero(input string nm);
        chk(nm, int'({bus.busy, bus.done, bus.bias_load, bus.pixel_addr, bus.pixel_rd,
                      bus.valid_pixel, bus.hid_addr, bus.hid_addr_d, bus.valid_hidden,
                      bus.class_addr, bus.valid_class} != '0), 0);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_run(output int b);
        @(negedge clk);
        b = cyc;
        push_run(b);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("start issued at cycle %0d", b);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (bus.bias_load != '0) check_ev(0, "bias_load", int'(bus.bias_load), 0);
        if (bus.pixel_rd) check_ev(1, "pixel_addr", int'(bus.pixel_addr), 0);
        else if (bus.pixel_addr != '0) chk("pixel_addr_idle", int'(bus.pixel_addr), 0);
        if (bus.valid_pixel) check_ev(2, "valid_pixel", 1, 0);
        if (bus.valid_hidden) check_ev(3, "hid_addr", int'(bus.hid_addr), int'(bus.hid_addr_d));
        else if (bus.hid_addr != '0) chk("hid_addr_idle", int'(bus.hid_addr), 0);
        if (bus.valid_class) check_ev(4, "class_addr", int'(bus.class_addr), 0);
        else if (bus.class_addr != '0) chk("class_addr_idle", int'(bus.class_addr), 0);
        if (bus.done) begin
            n_done++;
            check_ev(5, "done", 1, 0);
            $display("done seen at cycle %0d", cyc);
        end
        chk("busy", int'(bus.busy), busy_model(cyc));
    end

    // ------------------------------------------------------------------
    // Small-parameter instance
    // ------------------------------------------------------------------
    initial begin
        int b2;
        bit rd_hist[0:63];
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        for (int i = 0; i < 64; i++) rd_hist[i] = 1'b0;
        repeat (6) @(negedge clk);
        b2 = cyc;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int rel = 1; rel < 50; rel++) begin
            rd_hist[rel] = bus2.pixel_rd;
            chk("sw_pixel_rd", int'(bus2.pixel_rd), int'(rel >= S_NH + 1 && rel <= S_NH + S_NIN));
            chk("sw_valid_pixel_lag", int'(bus2.valid_pixel),
                (rel >= S_ML) ? int'(rd_hist[rel - S_ML]) : 0);
            chk("sw_bias_load", int'(bus2.bias_load), (rel >= 1 && rel <= S_NH) ? (1 << (rel - 1)) : 0);
            chk("sw_done", int'(bus2.done), int'(rel == S_D));
            chk("sw_busy", int'(bus2.busy), int'(rel >= 1 && rel <= S_D));
            @(negedge clk);
        end
        $display("small instance run from cycle %0d checked", b2);
        sweep_done = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int b;
        int r;
        int d0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1 rst_n = 1'b0;
        rst2_n = 1'b0;
        #1 check_zero("reset_outputs");
        chk("reset_small_busy", int'(bus2.busy), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // Single complete run.
        start_run(b);
        wait_until(b + D + 1);
        chk("single_run_done_count", n_done, 1);

        // start and abort together in IDLE: nothing happens.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_idle_busy", int'(bus.busy), 0);

        // Back-to-back: start held high, the second run begins right after IDLE.
        @(negedge clk);
        b = cyc;
        push_run(b);
        push_run(b + D + 1);
        d0 = n_done;
        bus.start = 1'b1;
        $display("start held high from cycle %0d", b);
        wait_until(b + 2*D + 1);
        bus.start = 1'b0;
        wait_until(b + 2*D + 10);
        chk("back_to_back_done_count", n_done - d0, 2);

        // Abort mid-PIXEL, then a fresh run.
        start_run(b);
        wait_until(b + 400);
        bus.abort = 1'b1;
        purge(b + 400);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_pixel_addr", int'(bus.pixel_addr), 0);
        chk("abort_valid_pixel", int'(bus.valid_pixel), 0);
        $display("abort issued at cycle %0d", b + 400);
        d0 = n_done;
        start_run(b);
        wait_until(b + D + 1);
        chk("after_abort_done_count", n_done - d0, 1);

        // Random aborts, with stray start pulses while busy.
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_run(b);
            r = $urandom_range(2, D);
            while (cyc < b + r) begin
                bus.start = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            bus.start = 1'b0;
            bus.abort = 1'b1;
            purge(b + r);
            @(negedge clk);
            bus.abort = 1'b0;
            $display("abort issued at run offset %0d", r);
            chk("random_abort_busy", int'(bus.busy), 0);
        end

        // Asynchronous reset in the middle of HIDDEN.
        start_run(b);
        wait_until(b + 805);
        d0 = n_done;
        #1 rst_n = 1'b0;
        purge(b + 805);
        #1 check_zero("async_reset_outputs");
        $display("reset asserted in cycle %0d", b + 805);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_done_count", n_done - d0, 0);
        chk("post_reset_busy", int'(bus.busy), 0);

        chk("leftover_events", q_bias.size() + q_pix.size() + q_vp.size() +
                               q_hid.size() + q_cls.size() + q_done.size(), 0);
        chk("small_instance_finished", int'(sweep_done), 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nn_seq_ctrl.md
# nn_seq_ctrl

Parametrised inference sequencer for the fully-connected MNIST datapath. On a `start` pulse it:

- walks the per-neuron bias loads;
- streams every input pixel address with a memory-latency-aligned valid;
- drains the MAC pipeline;
- sequences the hidden-layer outputs into the output layer;
- scans the class scores for argmax.

It then pulses `done` and returns to idle, so it can run back-to-back images. It sits between the pixel/weight memories and the layer-1/layer-2/argmax datapath.

## Interface
- `N_IN`, 784, number of input pixels per image
- `N_HID`, 10, number of hidden neurons (bias one-hot width)
- `N_OUT`, 10, number of output classes scanned by argmax
- `PIX_AW`, 12, pixel address width; requires 2^PIX_AW >= N_IN
- `HID_AW`, 4, hidden address width; requires 2^HID_AW >= N_HID
- `OUT_AW`, 4, class address width; requires 2^OUT_AW >= N_OUT
- `MEM_LAT`, 2, pixel/weight memory read latency in cycles; 1..7
- `DRAIN`, 7, pipeline drain cycles after each layer; requires DRAIN >= MEM_LAT

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one inference; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on completion
- `bias_load`  out  N_HID  one-hot bias load strobe
- `pixel_addr`  out  PIX_AW  pixel/weight read address
- `pixel_rd`  out  1  read enable, high while `pixel_addr` is live
- `valid_pixel`  out  1  `pixel_rd` delayed MEM_LAT cycles
- `hid_addr`  out  HID_AW  hidden-neuron select for layer 2
- `hid_addr_d`  out  HID_AW  `hid_addr` delayed 1 cycle
- `valid_hidden`  out  1  high while `hid_addr` is live
- `class_addr`  out  OUT_AW  class-score select for argmax
- `valid_class`  out  1  high while `class_addr` is live

## Operation
- All outputs are registered.
- Reset values: every output 0, state IDLE, all counters 0, all delay lines 0.
- State machine transitions:
  - IDLE→BIAS on `start`=1.
  - BIAS→PIXEL after N_HID cycles.
  - PIXEL→DRAIN1 after N_IN cycles.
  - DRAIN1→HIDDEN after DRAIN cycles.
  - HIDDEN→DRAIN2 after N_HID cycles.
  - DRAIN2→ARGMAX after DRAIN cycles.
  - ARGMAX→DONE after N_OUT cycles.
  - DONE→IDLE after 1 cycle.
- BIAS: in its k-th cycle (k=0..N_HID-1), `bias_load` = 1<<k. It is 0 in all other states.
- PIXEL: `pixel_addr` = 0..N_IN-1, one per cycle, with `pixel_rd`=1. On exit, `pixel_addr` returns to 0.
- `valid_pixel` is a MEM_LAT-deep shift register fed by `pixel_rd`. It keeps shifting through DRAIN1, so the last valid lands inside DRAIN1.
- HIDDEN: `hid_addr` = 0..N_HID-1 with `valid_hidden`=1. `hid_addr_d` tracks it 1 cycle late.
- ARGMAX: `class_addr` = 0..N_OUT-1 with `valid_class`=1.
- DONE: `done`=1 for exactly one cycle; `busy` is still 1.
- Addresses hold 0 outside their active state.
- `start` is ignored while `busy`=1.
- `abort`=1 in any non-IDLE state (including DONE):
  - next state is IDLE;
  - all counters, strobes and delay lines clear;
  - no `done` pulse.
- `abort` in IDLE has no effect. `start` and `abort` asserted together in IDLE: `abort` wins and the block stays IDLE.
- Counters compare against parameter-1 at full declared width. No wrap occurs inside a state.

## Timing
- Take `start` sampled at edge E0. Then:
  - BIAS occupies cycles 1..N_HID.
  - PIXEL occupies the next N_IN cycles.
  - Each drain state occupies DRAIN cycles.
- `done` falls in cycle 2·N_HID + N_IN + 2·DRAIN + N_OUT + 1. With defaults that is cycle 829.
- The earliest next `start` is accepted at the edge ending the DONE cycle's successor, i.e. in IDLE at cycle 830.
- `valid_pixel` for address a is high MEM_LAT cycles after `pixel_addr`=a.
- Asynchronous reset asserted mid-run forces all outputs to 0 immediately. Operation resumes in IDLE on the first edge after deassertion.

## Test plan
- Default parameters, single `start` pulse:
  - `bias_load` = 0x001..0x200 over cycles 1–10;
  - `pixel_addr` 0..783 in cycles 11–794;
  - `valid_pixel` high in cycles 13–796;
  - `hid_addr` 0..9 in cycles 802–811;
  - `class_addr` 0..9 in cycles 819–828;
  - `done` high only in cycle 829.
- Back-to-back: `start` held high continuously → second run's BIAS begins at cycle 831. Exactly two `done` pulses across 1660 cycles; no start accepted while `busy`.
- `abort` at cycle 400 (mid-PIXEL) → cycle 401: IDLE, `busy`=0, `pixel_addr`=0, `valid_pixel`=0 by cycle 401. No `done`. A fresh `start` then completes normally.
- `rst_n` low asynchronously mid-HIDDEN → all outputs 0 before the next edge. After release with no `start`, the block remains IDLE with `done` never asserted.
- Parameter sweep N_IN=16, N_HID=4, N_OUT=3, MEM_LAT=3, DRAIN=3 → `done` in cycle 34; `valid_pixel` lags `pixel_rd` by exactly 3 cycles; `bias_load` width 4.
- `start` and `abort` high together in IDLE → no transition, `busy` stays 0.
